serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a subtraction; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: minuend, captured on the accepting edge.
REQ-006 The block SHALL have port b, input, WIDTH bits: subtrahend, captured on the accepting edge.
REQ-007 The block SHALL have port bin, input, 1 bit: borrow-in, captured on the accepting edge.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN or DONE.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse marking d and bout as newly valid.
REQ-010 The block SHALL have port d, output, WIDTH bits: registered difference, a - b - bin mod 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit: registered borrow-out, 1 iff a < b + bin as unsigned values.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 on edge T, the block SHALL load the operand shift registers from a and b, load the borrow flop from bin, clear the bit counter and enter RUN.
REQ-014 In RUN, each edge SHALL apply a full subtractor to the LSBs of the operand registers and the borrow flop.
- diff = a0 ^ b0 ^ borrow
- next borrow = (~a0 & b0) | (~(a0 ^ b0) & borrow)
REQ-015 In RUN, each edge SHALL shift diff into the MSB of an internal result register, shift both operand registers right by one, update the borrow flop and increment the counter.
REQ-016 The block SHALL spend exactly WIDTH edges in RUN (edges T+1..T+WIDTH) and enter DONE on edge T+WIDTH.
REQ-017 On entering DONE, the block SHALL copy the completed result register to d and the final borrow to bout.
REQ-018 d and bout SHALL remain unchanged at all other times, including throughout RUN.
REQ-019 done SHALL be high exactly in the cycle following edge T+WIDTH.
REQ-020 DONE SHALL always return to IDLE on the next edge, so done is never longer than one cycle.
REQ-021 busy SHALL go high in the cycle after edge T and stay high through the DONE cycle; busy SHALL be 0 in IDLE.
REQ-022 start asserted in RUN or DONE SHALL be ignored, with no effect on operands, outputs or timing.
REQ-023 a, b and bin SHALL have no effect on the result after the accepting edge.
REQ-024 start held high continuously SHALL begin a new operation on the first IDLE edge after DONE, giving one result every WIDTH+2 cycles.
REQ-025 The bit counter SHALL be ceil(log2(WIDTH)) bits wide, and the RUN-to-DONE transition SHALL be taken when the counter equals WIDTH-1.

Reset
REQ-026 rst=1 at a clock edge SHALL force state IDLE and clear busy, done, d, bout, the borrow flop, the counter and all shift registers to 0.
REQ-027 rst SHALL take priority over start and SHALL abort any RUN or DONE in progress without a done pulse.
REQ-028 An operation SHALL be accepted no earlier than the first edge with rst=0 and start=1.

Structure
REQ-029 The state enumeration (IDLE, RUN, DONE) and the WIDTH default constant SHALL be placed in the shared package serial_arith_pkg.
REQ-030 The per-bit logic SHALL be a combinational sub-module, full_subtractor, with inputs a, b, bin and outputs d, bout.
REQ-031 serial_subtractor SHALL contain exactly one full_subtractor instance.
REQ-032 No arithmetic operator SHALL be used on the WIDTH-bit operands; the block SHALL be bit-serial only.

Verification
REQ-033 The bench SHALL run a=0101, b=0011, bin=0 -> after WIDTH+1 cycles, done pulse, d=0010, bout=0.
REQ-034 The bench SHALL run a=0011, b=0101, bin=0 -> d=1110, bout=1.
REQ-035 The bench SHALL run a=0000, b=0000, bin=1 -> d=1111, bout=1; then a=1000, b=0001, bin=0 -> d=0111, bout=0.
REQ-036 The bench SHALL start a=1111, b=0001, then pulse start with a=0000, b=1111 in RUN and change a and b mid-RUN -> d=1110, bout=0, exactly one done pulse.
REQ-037 The bench SHALL assert rst on the 2nd RUN cycle -> next cycle state IDLE, d=0000, bout=0, busy=0, no done pulse; a fresh start afterwards completes normally.
REQ-038 The bench SHALL hold start high for 3 operations -> done pulses exactly WIDTH+2 cycles apart, and every result SHALL match a reference model over all 512 (a, b, bin) combinations.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_arith_pkg;

    // Operand width used when a block is instantiated without overriding WIDTH.
    localparam int SERIAL_WIDTH_DEFAULT = 4;

    // Control states of the serial subtractor sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a (minuend bit), b (subtrahend bit), bin (borrow in),
//        d (difference bit), bout (borrow out).
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a outright, or when they match and a borrow is pending.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - bin mod 2^WIDTH, bout = borrow out.
// Latency: accept edge T, d/bout valid with done pulse in the cycle after edge T+WIDTH.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
// Ports: clk, rst (sync, active-high), start, a, b, bin in;
//        busy, done (1-cycle pulse), d, bout out (registered, held between results).
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int                CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

    serial_state_t    r_state;
    serial_state_t    w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_d;
    logic             r_bout;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    logic             w_diff;
    logic             w_borrow_nxt;
    logic             w_last;
    logic [WIDTH-1:0] w_res_nxt;

    full_subtractor u_fs (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_diff),
        .bout (w_borrow_nxt)
    );

    assign w_last    = (r_cnt == LAST);
    // Result fills from the top so the LSB ends up at bit 0 after WIDTH shifts.
    assign w_res_nxt = {w_diff, r_res[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and status outputs.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand shifters, borrow flop, counter and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_d      <= '0;
            r_bout   <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_a      <= {1'b0, r_a[WIDTH-1:1]};
                    r_b      <= {1'b0, r_b[WIDTH-1:1]};
                    r_res    <= w_res_nxt;
                    r_borrow <= w_borrow_nxt;
                    r_cnt    <= r_cnt + CW'(1);
                    // Publish on the final bit so d/bout are stable for the whole DONE cycle.
                    if (w_last) begin
                        r_d    <= w_res_nxt;
                        r_bout <= w_borrow_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign d    = r_d;
    assign bout = r_bout;

endmodule
